// File: rtl/test_status_csr_if.sv
// Writeback CSR-write bus plus combinational CSR read port for the test-status responder.
interface test_status_csr_if;
  logic        valid_wb_i;
  logic        stall_wb_i;
  logic        csr_we_wb_i;
  logic [11:0] csr_addr_wb_i;
  logic [31:0] csr_wdata_wb_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        csr_rhit_o;

  modport master (
    output valid_wb_i, stall_wb_i, csr_we_wb_i, csr_addr_wb_i, csr_wdata_wb_i, csr_raddr_i,
    input  csr_rdata_o, csr_rhit_o
  );

  modport slave (
    input  valid_wb_i, stall_wb_i, csr_we_wb_i, csr_addr_wb_i, csr_wdata_wb_i, csr_raddr_i,
    output csr_rdata_o, csr_rhit_o
  );
endinterface

// File: rtl/test_status_csr.sv
// Test-status CSR responder at writeback: sticky verdict, cycle watchdog, instret counter.
// Optional progress-code history enabled by defining TEST_STATUS_HIST_EN.
module test_status_csr #(
  parameter logic [11:0] CSR_ADDR       = 12'h7C0,
  parameter logic [31:0] PASS_CODE      = 32'h0000_0001,
  parameter logic [31:0] FAIL_CODE      = 32'h0000_000F,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  test_status_csr_if.slave bus,
  output logic [31:0]      status_code_o,
  output logic [1:0]       state_o,
  output logic             test_done_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      code_q, code_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic             retire, wr_acc;
  logic [11:0]      rd_off;

  assign retire = bus.valid_wb_i && !bus.stall_wb_i;
  assign wr_acc = retire && bus.csr_we_wb_i && (bus.csr_addr_wb_i == CSR_ADDR);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    // Terminal states hold everything; only RUN advances.
    if (state_q == ST_RUN) begin
      if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
      if (retire && inst_q != '1) inst_d = inst_q + CNT_W'(1);
      if (wr_acc) begin
        code_d = bus.csr_wdata_wb_i;
        if (bus.csr_wdata_wb_i == PASS_CODE)      state_d = ST_PASS;
        else if (bus.csr_wdata_wb_i == FAIL_CODE) state_d = ST_FAIL;
      end else if (cyc_q == TO_LAST) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_RUN;
      code_q  <= '0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef TEST_STATUS_HIST_EN
  logic [3:0][31:0] hist_q, hist_d;
  logic [1:0]       wptr_q, wptr_d;
  logic [2:0]       hcnt_q, hcnt_d;
  logic             push;
  logic [1:0]       hidx;

  assign push = wr_acc && (state_q == ST_RUN) &&
                (bus.csr_wdata_wb_i != PASS_CODE) && (bus.csr_wdata_wb_i != FAIL_CODE);
  // k-th most recent lives just behind the write pointer; offset 2 maps to k=0.
  assign hidx = wptr_q - 2'd1 - (rd_off[1:0] - 2'd2);

  always_comb begin
    hist_d = hist_q;
    wptr_d = wptr_q;
    hcnt_d = hcnt_q;
    if (push) begin
      hist_d[wptr_q] = bus.csr_wdata_wb_i;
      wptr_d         = wptr_q + 2'd1;
      if (hcnt_q != 3'd4) hcnt_d = hcnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      hist_q <= '0;
      wptr_q <= '0;
      hcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      wptr_q <= wptr_d;
      hcnt_q <= hcnt_d;
    end
  end
`endif

  assign rd_off = bus.csr_raddr_i - CSR_ADDR;

  always_comb begin
    bus.csr_rdata_o = '0;
    bus.csr_rhit_o  = 1'b0;
    case (rd_off)
      12'd0: begin
        bus.csr_rhit_o  = 1'b1;
        bus.csr_rdata_o = code_q;
      end
      12'd1: begin
        bus.csr_rhit_o  = 1'b1;
        bus.csr_rdata_o = {30'b0, state_q};
      end
`ifdef TEST_STATUS_HIST_EN
      12'd2, 12'd3, 12'd4, 12'd5: begin
        bus.csr_rhit_o  = 1'b1;
        bus.csr_rdata_o = hist_q[hidx];
      end
      12'd6: begin
        bus.csr_rhit_o  = 1'b1;
        bus.csr_rdata_o = {29'b0, hcnt_q};
      end
`endif
      default: ;
    endcase
  end

  assign status_code_o = code_q;
  assign state_o       = state_q;
  assign test_done_o   = (state_q != ST_RUN);
  assign cycle_cnt_o   = cyc_q;
  assign instret_cnt_o = inst_q;

endmodule

// File: doc/test_status_csr.md
Name: test_status_csr

Overview:
- Machine-mode CSR responder for the test-status register at the writeback stage of the pipelined core.
- Accepts retired CSR writes carrying pass, fail or progress codes, and latches a sticky test verdict.
- Runs a cycle watchdog and a retired-instruction counter.
- Exposes verdict, counters and a CSR read port, so that a bench, or a later host/debug block, only needs to sample `test_done_o` instead of probing datapath internals.

Parameters:
- `CSR_ADDR`, 12'h7C0, CSR address of the test-status register. CSR_ADDR+1 is the read-only state register.
- `PASS_CODE`, 32'h0000_0001, write value that ends the test as passed.
- `FAIL_CODE`, 32'h0000_000F, write value that ends the test as failed.
- `TIMEOUT_CYCLES`, 1000000, number of RUN cycles before the verdict is forced to TIMEOUT.
- `CNT_W`, 32, width of the cycle and instret counters.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: reset. Synchronous, active-low.
- `valid_wb_i` in 1: a valid instruction is in writeback.
- `stall_wb_i` in 1: writeback stage is stalled.
- `csr_we_wb_i` in 1: the writeback instruction writes a CSR.
- `csr_addr_wb_i` in 12: CSR address of the write.
- `csr_wdata_wb_i` in 32: CSR write data, i.e. the final CSR result.
- `csr_raddr_i` in 12: combinational read address.
- `csr_rdata_o` out 32: read data.
- `csr_rhit_o` out 1: `csr_raddr_i` decodes to a register owned by this block.
- `status_code_o` out 32: last accepted code.
- `state_o` out 2: 0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT.
- `test_done_o` out 1: state is not RUN.
- `cycle_cnt_o` out CNT_W: cycles spent in RUN.
- `instret_cnt_o` out CNT_W: instructions retired in RUN.

Behaviour:
- **Reset.** While `reset_i`=0 at a rising edge:
  - state=RUN;
  - `status_code_o`=0;
  - `cycle_cnt_o`=0;
  - `instret_cnt_o`=0;
  - `test_done_o`=0.
  - Reset mid-test (any state) restarts everything on the next edge.
- **Retire definition.** retire = `valid_wb_i` && !`stall_wb_i`.
- **Write accept.** A write is accepted when retire && `csr_we_wb_i` && `csr_addr_wb_i`==`CSR_ADDR`.
  - Writes while stalled, invalid, or to any other address are ignored.
  - A write to CSR_ADDR+1 is ignored (read-only).
- **Outputs are registered.** Every effect below is visible one cycle after the accepting edge.
- **State machine, RUN:**
  - accepted PASS_CODE -> PASS;
  - accepted FAIL_CODE -> FAIL;
  - any other accepted value -> stay in RUN (progress code);
  - in all of the above cases `status_code_o` <= data.
  - No accepted write and `cycle_cnt_o`==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - Simultaneous terminal write and timeout: the write wins.
- **Terminal states.** PASS, FAIL and TIMEOUT are sticky until reset. Further writes are ignored; `status_code_o` and the counters freeze.
- **cycle_cnt_o.** In RUN, +1 every cycle. It increments on the terminal transition edge as well.
- **instret_cnt_o.** In RUN, +1 per retire. A retiring terminal write is counted.
- **Saturation.** Both counters saturate at all-ones and never wrap.
- **Read port (combinational):**
  - CSR_ADDR -> `status_code_o`;
  - CSR_ADDR+1 -> {30'b0, `state_o`};
  - otherwise 0 with `csr_rhit_o`=0.

Optional Feature:
- Macro: `TEST_STATUS_HIST_EN`.
- **Enabled:**
  - Adds a 4-entry circular history of accepted non-terminal (progress) codes, plus a 3-bit count that saturates at 4.
  - Write pointer wraps 3->0, and the oldest entry is overwritten.
  - CSR_ADDR+2+k (k=0..3) reads the k-th most recent entry. Entries not yet written read as 0.
  - CSR_ADDR+6 reads the count.
  - `csr_rhit_o` is asserted for these addresses.
  - History clears on reset and freezes in terminal states.
- **Disabled:** none of this logic exists, and those addresses give `csr_rhit_o`=0 and data 0.

Test Plan:
1. Reset low 2 cycles, then high, then 10 idle cycles -> state=RUN, `test_done_o`=0, `cycle_cnt_o`=10, `instret_cnt_o`=0.
2. Retire write 32'h5 to 12'h7C0, then retire write 32'h1 -> `status_code_o`=1, state=PASS, `test_done_o`=1. A subsequent write of 32'hF leaves state=PASS and the counters frozen.
3. Write 32'hF with `stall_wb_i`=1 for 3 cycles, then released -> no change while stalled; FAIL one cycle after release; `instret_cnt_o` counts only the released retire.
4. `TIMEOUT_CYCLES`=20, no writes -> state=TIMEOUT after 20 RUN cycles, `cycle_cnt_o`=20. A FAIL_CODE write on cycle 19 instead -> FAIL.
5. Reset asserted while in FAIL -> state=RUN and all outputs 0 on the next cycle. Reading 12'h7C1 gives 0 and `csr_rhit_o`=1; reading 12'h300 gives `csr_rhit_o`=0.
6. With `TEST_STATUS_HIST_EN`, write progress codes 2,3,4,5,6 -> reading 7C2..7C5 gives 6,5,4,3 and 7C6 gives 4 (wrap verified).
